// File: rtl/led_pkg.sv
// Shared types and defaults for the rotating-LED receive-side monitor.
package led_pkg;

    // Lock progression: acquiring a legal pattern, locked on a position, running with a known direction
    typedef enum logic [1:0] {
        S_ACQ  = 2'd0,
        S_LOCK = 2'd1,
        S_RUN  = 2'd2
    } led_state_e;

    localparam int unsigned LED_WIDTH_DEFAULT = 5;
    localparam int unsigned LED_REV_W_DEFAULT = 8;

    // Rotation direction encoding as presented on the dir output
    localparam logic DIR_LEFT  = 1'b0;  // index increasing
    localparam logic DIR_RIGHT = 1'b1;  // index decreasing

endpackage : led_pkg

// File: rtl/led_onehot_decode.sv
// Combinational one-hot decoder: flags whether exactly one LED is lit and
// reports its index (index is only meaningful when legal_o is high).
module led_onehot_decode
    import led_pkg::*;
#(
    parameter int unsigned WIDTH = LED_WIDTH_DEFAULT,
    localparam int unsigned POS_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din_i,
    output logic             legal_o,
    output logic [POS_W-1:0] idx_o
);

    logic seen_one;
    logic seen_many;

    // Scan all bits once: remember the lit index and whether a second bit was found
    always_comb begin
        seen_one  = 1'b0;
        seen_many = 1'b0;
        idx_o     = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (din_i[i]) begin
                if (seen_one) begin
                    seen_many = 1'b1;
                end
                seen_one = 1'b1;
                idx_o    = POS_W'(i);
            end
        end
        legal_o = seen_one & ~seen_many;
    end

endmodule : led_onehot_decode

// File: rtl/led_rotation_monitor.sv
// Receiving end of the rotating-LED shifter: samples the one-hot LED bus on
// each tick, tracks position and direction, counts revolutions and flags
// illegal or skipped patterns.
module led_rotation_monitor
    import led_pkg::*;
#(
    parameter int unsigned WIDTH = LED_WIDTH_DEFAULT,
    parameter int unsigned REV_W = LED_REV_W_DEFAULT,
    localparam int unsigned POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic [POS_W-1:0] pos,
    output logic             valid,
    output logic             dir,
    output logic             dir_valid,
    output logic [REV_W-1:0] rev_count,
    output logic             rev_pulse,
    output logic             err,
    output logic             err_sticky
);

    localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WIDTH - 1);

    led_state_e       state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             valid_q, valid_d;
    logic             dir_q, dir_d;
    logic             dir_valid_q, dir_valid_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic             rev_pulse_q, rev_pulse_d;
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;

    logic             legal;
    logic [POS_W-1:0] idx;
    logic [POS_W-1:0] left_next;
    logic [POS_W-1:0] right_next;
    logic             step_left;
    logic             step_right;
    logic             same_idx;
    logic             wrap_step;
    logic             err_set;
    logic             wrap_hit;

    led_onehot_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .din_i   (din),
        .legal_o (legal),
        .idx_o   (idx)
    );

    // Neighbours of the current position and how the new sample relates to it
    always_comb begin
        left_next  = (pos_q == LAST_IDX) ? '0 : pos_q + POS_W'(1);
        right_next = (pos_q == '0) ? LAST_IDX : pos_q - POS_W'(1);
        step_left  = (idx == left_next);
        step_right = (idx == right_next);
        same_idx   = (idx == pos_q);
        wrap_step  = (step_left && (pos_q == LAST_IDX)) ||
                     (step_right && (pos_q == '0));
    end

    // Lock FSM: next state, position/direction tracking, error and wrap events
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        valid_d     = valid_q;
        dir_d       = dir_q;
        dir_valid_d = dir_valid_q;
        err_set     = 1'b0;
        wrap_hit    = 1'b0;
        if (tick) begin
            unique case (state_q)
                S_ACQ: begin
                    if (legal) begin
                        pos_d   = idx;
                        valid_d = 1'b1;
                        state_d = S_LOCK;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                // LOCK and RUN react identically; dir_valid is already low in LOCK,
                // so clearing it on a skip is harmless there.
                S_LOCK, S_RUN: begin
                    if (!legal) begin
                        err_set     = 1'b1;
                        valid_d     = 1'b0;
                        dir_valid_d = 1'b0;
                        state_d     = S_ACQ;
                    end else if (step_left || step_right) begin
                        pos_d       = idx;
                        dir_d       = step_left ? DIR_LEFT : DIR_RIGHT;
                        dir_valid_d = 1'b1;
                        wrap_hit    = wrap_step;
                        state_d     = S_RUN;
                    end else if (!same_idx) begin
                        err_set     = 1'b1;
                        dir_valid_d = 1'b0;
                        pos_d       = idx;
                        state_d     = S_LOCK;
                    end
                end
                default: begin
                    valid_d     = 1'b0;
                    dir_valid_d = 1'b0;
                    state_d     = S_ACQ;
                end
            endcase
        end
    end

    // Revolution counter, sticky error and the single-cycle event pulses; clr has priority
    always_comb begin
        rev_pulse_d  = wrap_hit;
        err_d        = err_set;
        rev_d        = rev_q + REV_W'(wrap_hit);
        err_sticky_d = err_sticky_q | err_set;
        if (clr) begin
            rev_d        = '0;
            err_sticky_d = 1'b0;
        end
    end

    // All state and outputs registered, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_ACQ;
            pos_q        <= '0;
            valid_q      <= 1'b0;
            dir_q        <= 1'b0;
            dir_valid_q  <= 1'b0;
            rev_q        <= '0;
            rev_pulse_q  <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            valid_q      <= valid_d;
            dir_q        <= dir_d;
            dir_valid_q  <= dir_valid_d;
            rev_q        <= rev_d;
            rev_pulse_q  <= rev_pulse_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign pos        = pos_q;
    assign valid      = valid_q;
    assign dir        = dir_q;
    assign dir_valid  = dir_valid_q;
    assign rev_count  = rev_q;
    assign rev_pulse  = rev_pulse_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;

endmodule : led_rotation_monitor

// File: tb/tb_led_rotation_monitor.sv
// Scoreboard bench for led_rotation_monitor (WIDTH=5, REV_W=8): the driver
// updates a behavioural model and queues the expected outputs; a monitor
// compares the DUT against the queue one time unit after each rising edge.
module tb_led_rotation_monitor;

    localparam int W  = 5;
    localparam int RW = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tick = 1'b0;
    logic [W-1:0] din = '0;
    logic         clr = 1'b0;
    logic [2:0]   pos;
    logic         valid;
    logic         dir;
    logic         dir_valid;
    logic [RW-1:0] rev_count;
    logic         rev_pulse;
    logic         err;
    logic         err_sticky;

    led_rotation_monitor #(
        .WIDTH (W),
        .REV_W (RW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .din        (din),
        .clr        (clr),
        .pos        (pos),
        .valid      (valid),
        .dir        (dir),
        .dir_valid  (dir_valid),
        .rev_count  (rev_count),
        .rev_pulse  (rev_pulse),
        .err        (err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    pos;
        logic          valid;
        logic          dir;
        logic          dir_valid;
        logic [RW-1:0] rev;
        logic          rev_pulse;
        logic          err;
        logic          err_sticky;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Behavioural model: "valid" and "dir known" flags stand in for the lock progression
    int m_pos;
    bit m_valid;
    bit m_dir;
    bit m_dvalid;
    int m_rev;
    bit m_sticky;
    bit m_rp;
    bit m_err;

    function automatic string fmt(obs_t o);
        return $sformatf("pos=%0d valid=%0b dir=%0b dir_valid=%0b rev=%0d rev_pulse=%0b err=%0b sticky=%0b",
                         o.pos, o.valid, o.dir, o.dir_valid, o.rev, o.rev_pulse, o.err, o.err_sticky);
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.pos = pos; o.valid = valid; o.dir = dir; o.dir_valid = dir_valid;
        o.rev = rev_count; o.rev_pulse = rev_pulse; o.err = err; o.err_sticky = err_sticky;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.pos = 3'(m_pos); o.valid = m_valid; o.dir = m_dir; o.dir_valid = m_dvalid;
        o.rev = RW'(m_rev); o.rev_pulse = m_rp; o.err = m_err; o.err_sticky = m_sticky;
        return o;
    endfunction

    function automatic logic [W-1:0] oh(int i);
        logic [W-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_valid = 0; m_dir = 0; m_dvalid = 0;
        m_rev = 0; m_sticky = 0; m_rp = 0; m_err = 0;
    endtask

    task automatic model_step(bit t, logic [W-1:0] d, bit c);
        int idx;
        int delta;
        m_rp  = 0;
        m_err = 0;
        if (t) begin
            if ($countones(d) != 1) begin
                m_err = 1; m_valid = 0; m_dvalid = 0;
            end else begin
                idx = $clog2(d);
                if (!m_valid) begin
                    m_pos = idx; m_valid = 1;
                end else begin
                    delta = (idx - m_pos + W) % W;
                    if (delta == 1 || delta == W - 1) begin
                        m_dir    = (delta == W - 1);
                        m_dvalid = 1;
                        m_rp     = (delta == 1 && idx == 0) || (delta == W - 1 && idx == W - 1);
                        m_pos    = idx;
                    end else if (delta != 0) begin
                        m_err = 1; m_dvalid = 0; m_pos = idx;
                    end
                end
            end
        end
        if (c) begin
            m_rev = 0; m_sticky = 0;
        end else begin
            m_rev = (m_rev + int'(m_rp)) % (1 << RW);
            m_sticky = m_sticky | m_err;
        end
    endtask

    task automatic check(string name, obs_t a, obs_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(a), fmt(e));
        end
    endtask

    // Drive one cycle's inputs and queue what the outputs must read after the coming edge
    task automatic apply(bit t, logic [W-1:0] d, bit c, string tag);
        @(negedge clk);
        tick = t; din = d; clr = c;
        if (reset) begin
            model_step(t, d, c);
        end else begin
            model_reset();
        end
        exp_q.push_back(model_obs());
        tag_q.push_back(tag);
    endtask

    task automatic async_reset_pulse(int hold_cycles);
        obs_t zero;
        zero = '0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_reset", dut_obs(), zero);
        for (int i = 0; i < hold_cycles; i++) begin
            apply(1'b1, oh($urandom_range(0, W - 1)), 1'b0, "held_in_reset");
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic rotate_left_until(int rev_target, int pos_target, string tag);
        int guard;
        guard = 0;
        while (!(m_rev == rev_target && m_pos == pos_target && m_valid) && guard < 3000) begin
            apply(1'b1, oh((m_pos + 1) % W), 1'b0, tag);
            guard++;
        end
    endtask

    // Monitor: pop and compare one expectation per edge
    always @(posedge clk) begin
        obs_t  e;
        string t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, dut_obs(), e);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t zero;
        int   r;
        bit   t;
        bit   c;
        logic [W-1:0] d;

        zero = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", dut_obs(), zero);
        @(posedge clk);
        #3;
        reset = 1'b1;

        // Left rotation with a wrap on the sixth sample
        apply(1, 5'b00001, 0, "t1_left");
        apply(1, 5'b00010, 0, "t1_left");
        apply(1, 5'b00100, 0, "t1_left");
        apply(1, 5'b01000, 0, "t1_left");
        apply(1, 5'b10000, 0, "t1_left");
        apply(1, 5'b00001, 0, "t1_left_wrap");

        // Illegal sample together with clr: err pulses but sticky stays clear
        apply(1, 5'b00000, 1, "t2_err_with_clr");
        apply(1, 5'b00001, 0, "t2_right");
        apply(1, 5'b10000, 0, "t2_right_wrap");
        apply(1, 5'b01000, 0, "t2_right");

        // Illegal pattern drops lock; next legal sample re-acquires
        apply(1, 5'b00100, 0, "t3_right");
        apply(1, 5'b00011, 0, "t3_illegal");
        apply(1, 5'b00100, 0, "t3_reacquire");

        // Skip while locked, then an adjacent step establishes direction
        apply(1, 5'b11111, 0, "t4_illegal");
        apply(1, 5'b00001, 0, "t4_acquire");
        apply(1, 5'b00100, 0, "t4_skip");
        apply(1, 5'b01000, 0, "t4_step");
        apply(1, 5'b00100, 0, "t4_reverse");
        apply(1, 5'b00100, 0, "t4_stall");

        // Revolution counter at its maximum: wrap with clr, then natural rollover
        apply(0, 5'b00000, 1, "t5_clr");
        rotate_left_until(255, W - 1, "t5_spin");
        apply(1, oh(0), 1, "t5_wrap_clr");
        rotate_left_until(255, W - 1, "t5_spin2");
        apply(1, oh(0), 0, "t5_wrap_roll");

        // Tick low: din ignored
        for (int i = 0; i < 4; i++) begin
            apply(0, W'($urandom), 0, "t6_tick_low");
        end

        // Asynchronous reset mid-run, then re-acquire
        apply(1, oh((m_pos + 1) % W), 0, "t6_pre_reset");
        async_reset_pulse(3);
        apply(1, 5'b01000, 0, "t6_reacquire");

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: d = oh((m_pos + 1) % W);
                4, 5:       d = oh((m_pos + W - 1) % W);
                6:          d = oh(m_pos);
                7:          d = oh($urandom_range(0, W - 1));
                8:          d = '0;
                default:    d = W'($urandom);
            endcase
            t = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 31) == 0);
            apply(t, d, c, "random");
            if (n == 750) begin
                async_reset_pulse(2);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_led_rotation_monitor
